digilock_lockout_ctrl: RTL and testbench
========================================

// Module: digilock_lockout_ctrl
// PURPOSE
//   Attempt/lockout controller; sits directly upstream of the 9-bit lockout counter.
//   - Counts consecutive failed code entries. After MAX_FAILS failures it enters lockout.
//   - In lockout it clears the counter, then drives the counter's add input until the
//     counter's terminal output s rises; it then re-arms the keypad.
//   - Also tracks the unlocked state of the door.
// PARAMETERS
//   MAX_FAILS  3  consecutive failures that trigger lockout (legal range 1..7)
//   FAIL_W     3  width of fail_count; must satisfy 2**FAIL_W > MAX_FAILS
// PORTS
//   clk         in   1       system clock; all logic on rising edge
//   reset       in   1       synchronous, active-low reset (0 = reset)
//   pass_ok     in   1       1-cycle pulse: entered code correct
//   pass_fail   in   1       1-cycle pulse: entered code wrong
//   lock_cmd    in   1       1-cycle pulse: user relocks the door
//   cnt_done    in   1       counter terminal output (counter s), level
//   cnt_add     out  1       counter add/enable; high only in LK_WAIT
//   cnt_reset   out  1       counter clear, active-high; low only in LK_WAIT
//   unlocked    out  1       door open; high only in UNLOCKED
//   locked_out  out  1       keypad disabled; high in LK_CLR and LK_WAIT
//   fail_count  out  FAIL_W  consecutive failures so far
// BEHAVIOUR
//   - All outputs are Moore outputs, decoded from registered state and fail_count.
//     An input sampled at edge N is reflected on the outputs after edge N.
//   - reset=0 at any edge, including mid-lockout: state=IDLE, fail_count=0.
//     Outputs: cnt_add=0, cnt_reset=1, unlocked=0, locked_out=0.
//   - IDLE
//     - pass_fail && fail_count==MAX_FAILS-1 -> LK_CLR, fail_count=0
//     - pass_fail otherwise                  -> fail_count+1, stay in IDLE
//     - pass_ok                              -> UNLOCKED, fail_count=0
//     - pass_ok and pass_fail in the same cycle: pass_fail wins, pass_ok is ignored.
//   - UNLOCKED
//     - lock_cmd -> IDLE; pass_ok and pass_fail are ignored.
//   - LK_CLR (exactly 1 cycle)
//     - cnt_reset=1, cnt_add=0 -> LK_WAIT unconditionally.
//   - LK_WAIT
//     - cnt_add=1, cnt_reset=0.
//     - cnt_done=1 -> IDLE; in IDLE cnt_reset=1 holds the counter cleared.
//     - cnt_done is ignored in every state other than LK_WAIT.
//   - While locked_out=1: pass_ok, pass_fail and lock_cmd are ignored.
//     fail_count stays 0.
//   - fail_count never exceeds MAX_FAILS-1; there is no wrap-around.
//   - No illegal-state lock-up: any unused state encoding -> IDLE on the next edge.
// CONFIGURATION
//   DIGILOCK_ESCALATE_EN
//     - Defined: adds a 3-bit lock_level register, reset 0, saturating at 4.
//       It increments on each LK_CLR entry and is cleared by pass_ok.
//     - LK_WAIT exits only after lock_level rising edges of cnt_done.
//       Between expirations, LK_WAIT pulses cnt_reset=1 / cnt_add=0 for one cycle.
//     - Undefined: one cnt_done expiration ends lockout; no lock_level register.
// TESTING
//   1. reset=0 for 2 cycles, then 1 -> unlocked=0, locked_out=0, cnt_reset=1, fail_count=0.
//   2. pass_fail x2, then pass_ok -> fail_count 1,2, then 0; unlocked=1.
//      Then lock_cmd -> unlocked=0.
//   3. pass_fail x3 -> locked_out=1; cnt_reset=1 for 1 cycle; then cnt_add=1.
//      pass_ok during lockout is ignored. cnt_done=1 -> next cycle IDLE, cnt_add=0, cnt_reset=1.
//   4. pass_ok and pass_fail in the same cycle while in IDLE -> fail_count=1, unlocked=0.
//   5. reset=0 while in LK_WAIT -> next edge: locked_out=0, cnt_add=0, cnt_reset=1.
//   6. ESCALATE_EN: two lockouts with no pass_ok between them.
//      -> the 2nd lockout needs 2 cnt_done pulses; locked_out=1 after the 1st pulse.

Source files
------------

// File: rtl/digilock_lockout_ctrl.sv
// -----------------------------------------------------------------------------
// digilock_lockout_ctrl
//   Attempt/lockout controller placed directly upstream of the 9-bit lockout
//   counter. It counts consecutive failed code entries and, once MAX_FAILS is
//   reached, enters lockout. Lockout clears the counter for one cycle and then
//   enables it until the counter's terminal output (cnt_done) rises. The block
//   also tracks whether the door is unlocked.
//
//   All outputs are registered Moore outputs. They are decoded from the next
//   state so that they line up with the state register.
//
//   Optional feature macro: DIGILOCK_ESCALATE_EN
//     When defined, a 3-bit lock_level register (saturating at 4) counts
//     lockouts since the last correct code. A lockout then lasts lock_level
//     counter expirations, with a one-cycle counter clear between them.
// -----------------------------------------------------------------------------
module digilock_lockout_ctrl #(
    parameter int MAX_FAILS = 3,
    parameter int FAIL_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pass_ok,
    input  logic              pass_fail,
    input  logic              lock_cmd,
    input  logic              cnt_done,
    output logic              cnt_add,
    output logic              cnt_reset,
    output logic              unlocked,
    output logic              locked_out,
    output logic [FAIL_W-1:0] fail_count
);

    // The failure count that triggers lockout on the next wrong code.
    localparam logic [FAIL_W-1:0] LAST_FAIL = FAIL_W'(MAX_FAILS - 1);

    // The enum spans 3 bits so that unused encodings exist and can be
    // steered back to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_UNLOCKED  = 3'd1,
        ST_LK_CLR    = 3'd2,
        ST_LK_WAIT   = 3'd3,
        ST_LK_RELOAD = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [FAIL_W-1:0] fail_count_q, fail_count_d;
    logic              cnt_add_q, cnt_add_d;
    logic              cnt_reset_q, cnt_reset_d;
    logic              unlocked_q, unlocked_d;
    logic              locked_out_q, locked_out_d;

`ifdef DIGILOCK_ESCALATE_EN
    logic [2:0] lock_level_q, lock_level_d;
    logic [2:0] exp_cnt_q, exp_cnt_d;
`endif

    // Next-state, failure-count and output decode.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the
        // case can leave one unassigned and infer a latch.
        state_d      = state_q;
        fail_count_d = fail_count_q;
`ifdef DIGILOCK_ESCALATE_EN
        lock_level_d = lock_level_q;
        exp_cnt_d    = exp_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A wrong code takes priority over a correct code in the
                // same cycle.
                if (pass_fail) begin
                    if (fail_count_q >= LAST_FAIL) begin
                        state_d      = ST_LK_CLR;
                        fail_count_d = '0;
`ifdef DIGILOCK_ESCALATE_EN
                        lock_level_d = (lock_level_q >= 3'd4) ? 3'd4 : lock_level_q + 3'd1;
`endif
                    end else begin
                        fail_count_d = fail_count_q + 1'b1;
                    end
                end else if (pass_ok) begin
                    state_d      = ST_UNLOCKED;
                    fail_count_d = '0;
`ifdef DIGILOCK_ESCALATE_EN
                    lock_level_d = '0;
`endif
                end
            end

            ST_UNLOCKED: begin
                fail_count_d = '0;
                if (lock_cmd) begin
                    state_d = ST_IDLE;
                end
            end

            ST_LK_CLR: begin
                fail_count_d = '0;
                state_d      = ST_LK_WAIT;
`ifdef DIGILOCK_ESCALATE_EN
                exp_cnt_d    = '0;
`endif
            end

            ST_LK_WAIT: begin
                fail_count_d = '0;
                if (cnt_done) begin
`ifdef DIGILOCK_ESCALATE_EN
                    // Leave only once the current level's worth of
                    // expirations has been seen; otherwise clear and rerun.
                    if (exp_cnt_q + 3'd1 >= lock_level_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        exp_cnt_d = exp_cnt_q + 3'd1;
                        state_d   = ST_LK_RELOAD;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end

`ifdef DIGILOCK_ESCALATE_EN
            ST_LK_RELOAD: begin
                fail_count_d = '0;
                state_d      = ST_LK_WAIT;
            end
`endif

            default: begin
                state_d      = ST_IDLE;
                fail_count_d = '0;
            end
        endcase

        // Moore decode of the state being entered.
        cnt_add_d    = (state_d == ST_LK_WAIT);
        cnt_reset_d  = (state_d != ST_LK_WAIT);
        unlocked_d   = (state_d == ST_UNLOCKED);
        locked_out_d = (state_d == ST_LK_CLR) || (state_d == ST_LK_WAIT) ||
                       (state_d == ST_LK_RELOAD);
    end

    // State, counters and registered outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples pre-edge values no matter what order the statements are in.
        if (!reset) begin
            state_q      <= ST_IDLE;
            fail_count_q <= '0;
            cnt_add_q    <= 1'b0;
            cnt_reset_q  <= 1'b1;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
`ifdef DIGILOCK_ESCALATE_EN
            lock_level_q <= '0;
            exp_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fail_count_q <= fail_count_d;
            cnt_add_q    <= cnt_add_d;
            cnt_reset_q  <= cnt_reset_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
`ifdef DIGILOCK_ESCALATE_EN
            lock_level_q <= lock_level_d;
            exp_cnt_q    <= exp_cnt_d;
`endif
        end
    end

    assign cnt_add    = cnt_add_q;
    assign cnt_reset  = cnt_reset_q;
    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_digilock_lockout_ctrl.sv
// -----------------------------------------------------------------------------
// tb_digilock_lockout_ctrl
//   Directed scenarios followed by randomized traffic. Expected outputs come
//   from a behavioural model of the lock: a failure tally, a door-open flag and
//   a lockout phase.
// -----------------------------------------------------------------------------
module tb_digilock_lockout_ctrl;

    localparam int MAX_FAILS = 3;
    localparam int FAIL_W    = 3;

    // Lockout phases of the model.
    localparam int PH_NONE   = 0;
    localparam int PH_CLEAR  = 1;
    localparam int PH_WAIT   = 2;
    localparam int PH_RELOAD = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              pass_ok, pass_fail, lock_cmd, cnt_done;
    logic              cnt_add, cnt_reset, unlocked, locked_out;
    logic [FAIL_W-1:0] fail_count;

    int checks = 0;
    int errors = 0;

    // Model state.
    int m_fails;
    bit m_open;
    int m_phase;
    int m_level;
    int m_expired;

    digilock_lockout_ctrl #(.MAX_FAILS(MAX_FAILS), .FAIL_W(FAIL_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pass_ok    (pass_ok),
        .pass_fail  (pass_fail),
        .lock_cmd   (lock_cmd),
        .cnt_done   (cnt_done),
        .cnt_add    (cnt_add),
        .cnt_reset  (cnt_reset),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .fail_count (fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge worth of inputs to the model.
    task automatic model_edge(input bit rst, input bit ok, input bit fail,
                              input bit lck, input bit done);
        if (!rst) begin
            m_fails   = 0;
            m_open    = 1'b0;
            m_phase   = PH_NONE;
            m_level   = 0;
            m_expired = 0;
        end else if (m_phase == PH_CLEAR) begin
            m_phase   = PH_WAIT;
            m_expired = 0;
        end else if (m_phase == PH_RELOAD) begin
            m_phase = PH_WAIT;
        end else if (m_phase == PH_WAIT) begin
            if (done) begin
`ifdef DIGILOCK_ESCALATE_EN
                m_expired++;
                m_phase = (m_expired >= m_level) ? PH_NONE : PH_RELOAD;
`else
                m_phase = PH_NONE;
`endif
            end
        end else if (m_open) begin
            if (lck) m_open = 1'b0;
        end else if (fail) begin
            m_fails++;
            if (m_fails == MAX_FAILS) begin
                m_fails = 0;
                m_phase = PH_CLEAR;
                m_level = (m_level >= 4) ? 4 : m_level + 1;
            end
        end else if (ok) begin
            m_open  = 1'b1;
            m_fails = 0;
            m_level = 0;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input bit rst, input bit ok, input bit fail,
                        input bit lck, input bit done);
        @(negedge clk);
        reset     = rst;
        pass_ok   = ok;
        pass_fail = fail;
        lock_cmd  = lck;
        cnt_done  = done;
        @(posedge clk);
        model_edge(rst, ok, fail, lck, done);
        #1;
        check("cnt_add",    32'(cnt_add),    32'(m_phase == PH_WAIT));
        check("cnt_reset",  32'(cnt_reset),  32'(m_phase != PH_WAIT));
        check("unlocked",   32'(unlocked),   32'(m_open));
        check("locked_out", 32'(locked_out), 32'(m_phase != PH_NONE));
        check("fail_count", 32'(fail_count), 32'(m_fails));
    endtask

    initial begin
        reset     = 1'b0;
        pass_ok   = 1'b0;
        pass_fail = 1'b0;
        lock_cmd  = 1'b0;
        cnt_done  = 1'b0;

        // 1. Reset for two cycles, then release.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_unlocked",   32'(unlocked),   32'd0);
        check("rst_locked_out", 32'(locked_out), 32'd0);
        check("rst_cnt_reset",  32'(cnt_reset),  32'd1);
        check("rst_cnt_add",    32'(cnt_add),    32'd0);
        check("rst_fail_count", 32'(fail_count), 32'd0);
        step(1, 0, 0, 0, 0);

        // 2. Two failures, then a correct code, then relock.
        step(1, 0, 1, 0, 0);
        check("t2_fail1", 32'(fail_count), 32'd1);
        step(1, 0, 1, 0, 0);
        check("t2_fail2", 32'(fail_count), 32'd2);
        step(1, 1, 0, 0, 0);
        check("t2_clear", 32'(fail_count), 32'd0);
        check("t2_open",  32'(unlocked),   32'd1);
        step(1, 1, 1, 0, 1);
        check("t2_ignore", 32'(unlocked), 32'd1);
        step(1, 0, 0, 1, 0);
        check("t2_relock", 32'(unlocked), 32'd0);

        // 3. Three failures trigger lockout; pass_ok is ignored meanwhile.
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        check("t3_locked",  32'(locked_out), 32'd1);
        check("t3_clr",     32'(cnt_reset),  32'd1);
        check("t3_clr_add", 32'(cnt_add),    32'd0);
        step(1, 1, 0, 0, 0);
        check("t3_add",   32'(cnt_add),  32'd1);
        check("t3_nounl", 32'(unlocked), 32'd0);
        step(1, 0, 1, 1, 0);
        check("t3_fc0", 32'(fail_count), 32'd0);
        step(1, 0, 0, 0, 1);
        check("t3_exit_lo",  32'(locked_out), 32'd0);
        check("t3_exit_add", 32'(cnt_add),    32'd0);
        check("t3_exit_rst", 32'(cnt_reset),  32'd1);

        // cnt_done outside LK_WAIT has no effect.
        step(1, 0, 0, 0, 1);

        // 4. pass_ok and pass_fail together in IDLE: the failure wins.
        step(1, 1, 1, 0, 0);
        check("t4_fc",  32'(fail_count), 32'd1);
        check("t4_unl", 32'(unlocked),   32'd0);

        // 5. Reset in the middle of LK_WAIT.
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        check("t5_wait", 32'(cnt_add), 32'd1);
        step(0, 0, 0, 0, 0);
        check("t5_lo",  32'(locked_out), 32'd0);
        check("t5_add", 32'(cnt_add),    32'd0);
        check("t5_rst", 32'(cnt_reset),  32'd1);
        step(1, 0, 0, 0, 0);

`ifdef DIGILOCK_ESCALATE_EN
        // 6. Two lockouts with no correct code in between.
        for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        check("t6_still_locked", 32'(locked_out), 32'd1);
        check("t6_reload",       32'(cnt_reset),  32'd1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        check("t6_exit", 32'(locked_out), 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 200) != 0,
                 ($urandom % 5) == 0,
                 ($urandom % 3) == 0,
                 ($urandom % 4) == 0,
                 ($urandom % 4) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
